// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the EX-stage ALU decoder and the iterative
// multiply/divide unit.
package alu_ctrl_pkg;

   typedef enum logic [1:0] {
      LDST   = 2'b00,
      BRANCH = 2'b01,
      ALU    = 2'b10,
      JUMP   = 2'b11
   } aluop_e;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_BEQ = 4'b1000;
   localparam logic [3:0] OP_BGE = 4'b1001;
   localparam logic [3:0] OP_BNE = 4'b1010;
   localparam logic [3:0] OP_SLT = 4'b1100;

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } md_funct3_e;

   localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } mdu_state_e;

endpackage

// File: rtl/alu_ctrl_mdu_if.sv
// EX-stage bundle between the pipeline (master) and the ALU control / MDU
// block (slave).
interface alu_ctrl_mdu_if #(
   parameter int XLEN = 32,
   parameter int OP_W = 4
);

   logic            valid_i;
   logic [1:0]      ALUOp;
   logic [6:0]      Funct7;
   logic [2:0]      Funct3;
   logic            is_rtype_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic            ex_ready_i;
   logic            flush_i;
   logic [OP_W-1:0] Operation;
   logic            md_sel;
   logic [XLEN-1:0] md_result;
   logic            stall_o;

   modport master (
      output valid_i, ALUOp, Funct7, Funct3, is_rtype_i, rs1_i, rs2_i,
             ex_ready_i, flush_i,
      input  Operation, md_sel, md_result, stall_o
   );

   modport slave (
      input  valid_i, ALUOp, Funct7, Funct3, is_rtype_i, rs1_i, rs2_i,
             ex_ready_i, flush_i,
      output Operation, md_sel, md_result, stall_o
   );

endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: FSM, step counter and the shared
// shift-add / restoring-subtract datapath. MDU_FAST_MUL_EN makes MUL* single-cycle.
module mdu_iter
   import alu_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            flush,
   input  logic            ex_ready,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output mdu_state_e      state,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_INIT = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e        state_n;
   logic [CW-1:0]     count, count_n;
   logic [2*XLEN-1:0] acc, acc_n;
   logic [XLEN-1:0]   opnd, opnd_n, result_n;
   logic [2:0]        f3_q, f3_n;
   logic              neg_lo, neg_lo_n, neg_hi, neg_hi_n;

   logic              is_div, a_signed, b_signed, rs1_neg, rs2_neg;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   mag1, mag2;

   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0] step, fin;
   logic [XLEN-1:0]   calc_res;

   assign is_div   = funct3[2];
   assign a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
   assign b_signed = is_div ? ~funct3[0] : ~funct3[1];
   assign rs1_neg  = a_signed & rs1[XLEN-1];
   assign rs2_neg  = b_signed & rs2[XLEN-1];
   assign mag1     = rs1_neg ? -rs1 : rs1;
   assign mag2     = rs2_neg ? -rs2 : rs2;
   assign div_zero = is_div & (rs2 == '0);
   assign div_ovf  = is_div & ~funct3[0] & (rs1 == SMIN) & (rs2 == '1);

`ifdef MDU_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   assign fast_prod = {{XLEN{rs1_neg}}, rs1} * {{XLEN{rs2_neg}}, rs2};
`endif

   // acc holds {partial product} for MUL* and {remainder, quotient} for DIV*;
   // the final step folds in the sign fix-up before the result is captured.
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
      div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd};
      if (f3_q[2]) begin
         step = {(div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                 acc[XLEN-2:0], ~div_diff[XLEN]};
         fin  = {(neg_hi ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN]),
                 (neg_lo ? -step[XLEN-1:0] : step[XLEN-1:0])};
      end else begin
         step = {mul_sum, acc[XLEN-1:1]};
         fin  = neg_lo ? -step : step;
      end
      case (md_funct3_e'(f3_q))
         MUL, DIV, DIVU: calc_res = fin[XLEN-1:0];
         default:        calc_res = fin[2*XLEN-1:XLEN];
      endcase
   end

   // Next-state logic; flush abandons whatever is in flight.
   always_comb begin
      state_n  = state;
      count_n  = count;
      acc_n    = acc;
      opnd_n   = opnd;
      f3_n     = f3_q;
      neg_lo_n = neg_lo;
      neg_hi_n = neg_hi;
      result_n = result;
      if (flush) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  f3_n     = funct3;
                  neg_lo_n = rs1_neg ^ rs2_neg;
                  neg_hi_n = is_div ? rs1_neg : (rs1_neg ^ rs2_neg);
                  if (div_zero) begin
                     result_n = funct3[1] ? rs1 : {XLEN{1'b1}};
                     state_n  = DONE;
                  end else if (div_ovf) begin
                     result_n = funct3[1] ? {XLEN{1'b0}} : rs1;
                     state_n  = DONE;
                  end
`ifdef MDU_FAST_MUL_EN
                  else if (!is_div) begin
                     result_n = (funct3 == 3'b000) ? fast_prod[XLEN-1:0]
                                                   : fast_prod[2*XLEN-1:XLEN];
                     state_n  = DONE;
                  end
`endif
                  else begin
                     acc_n   = is_div ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
                     opnd_n  = is_div ? mag2 : mag1;
                     count_n = CNT_INIT;
                     state_n = CALC;
                  end
               end
            end
            CALC: begin
               acc_n = step;
               if (count == '0) begin
                  result_n = calc_res;
                  state_n  = DONE;
               end else begin
                  count_n = count - 1'b1;
               end
            end
            DONE: begin
               if (ex_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         count  <= '0;
         acc    <= '0;
         opnd   <= '0;
         f3_q   <= '0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         result <= '0;
      end else begin
         state  <= state_n;
         count  <= count_n;
         acc    <= acc_n;
         opnd   <= opnd_n;
         f3_q   <= f3_n;
         neg_lo <= neg_lo_n;
         neg_hi <= neg_hi_n;
         result <= result_n;
      end
   end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU operation decoder with RV32M/RV64M multiply/divide support.
// Define MDU_FAST_MUL_EN for a single-cycle combinational multiplier.
module alu_ctrl_mdu
   import alu_ctrl_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int OP_W = 4
) (
   input logic           clk,
   input logic           reset_n,
   alu_ctrl_mdu_if.slave bus
);

   logic            m_op;
   logic [3:0]      op4;
   mdu_state_e      md_state;
   logic [XLEN-1:0] md_res;

   assign m_op = bus.valid_i & (bus.ALUOp == ALU) & bus.is_rtype_i &
                 (bus.Funct7 == FUNCT7_MEXT);

   // Only Funct7[5] matters here; SUB additionally needs an R-type so ADDI
   // with imm[10] set still adds.
   always_comb begin
      op4 = OP_ADD;
      if (!m_op) begin
         case (aluop_e'(bus.ALUOp))
            LDST: op4 = OP_ADD;
            BRANCH: begin
               case (bus.Funct3)
                  3'b000:         op4 = OP_BEQ;
                  3'b001:         op4 = OP_BNE;
                  3'b100, 3'b110: op4 = OP_SLT;
                  3'b101, 3'b111: op4 = OP_BGE;
                  default:        op4 = OP_BEQ;
               endcase
            end
            ALU: begin
               case (bus.Funct3)
                  3'b000:  op4 = (bus.is_rtype_i & bus.Funct7[5]) ? OP_SUB : OP_ADD;
                  3'b001:  op4 = OP_SLL;
                  3'b010:  op4 = OP_SLT;
                  3'b011:  op4 = OP_SLT;
                  3'b100:  op4 = OP_XOR;
                  3'b101:  op4 = bus.Funct7[5] ? OP_SRA : OP_SRL;
                  3'b110:  op4 = OP_OR;
                  default: op4 = OP_AND;
               endcase
            end
            JUMP:    op4 = OP_AND;
            default: op4 = OP_ADD;
         endcase
      end
   end

   mdu_iter #(.XLEN(XLEN)) u_mdu (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (m_op),
      .flush    (bus.flush_i),
      .ex_ready (bus.ex_ready_i),
      .funct3   (bus.Funct3),
      .rs1      (bus.rs1_i),
      .rs2      (bus.rs2_i),
      .state    (md_state),
      .result   (md_res)
   );

   assign bus.Operation = OP_W'(op4);
   assign bus.stall_o   = ~bus.flush_i & (((md_state == IDLE) & m_op) | (md_state == CALC));
   assign bus.md_sel    = ~bus.flush_i & (md_state == DONE);
   assign bus.md_result = md_res;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench for alu_ctrl_mdu: decode table, randomized M-ops against
// an arithmetic reference, hold/flush/reset behaviour.
module tb_alu_ctrl_mdu;
   import alu_ctrl_pkg::*;

   localparam int XLEN = 32;
   localparam logic [31:0] SMIN = 32'h8000_0000;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checkCount = 0;
   int   passCount = 0;

   alu_ctrl_mdu_if #(.XLEN(XLEN), .OP_W(4)) bus();

   alu_ctrl_mdu #(.XLEN(XLEN), .OP_W(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic valid, input logic [1:0] aluop,
                                input logic [6:0] f7, input logic [2:0] f3,
                                input logic rtype, input logic [31:0] a,
                                input logic [31:0] b, input logic exReady,
                                input logic flush);
      bus.valid_i    = valid;
      bus.ALUOp      = aluop;
      bus.Funct7     = f7;
      bus.Funct3     = f3;
      bus.is_rtype_i = rtype;
      bus.rs1_i      = a;
      bus.rs2_i      = b;
      bus.ex_ready_i = exReady;
      bus.flush_i    = flush;
   endtask

   // Reference decode, written straight from the operation table.
   function automatic logic [3:0] refOp(logic valid, logic [1:0] aluop, logic [2:0] f3,
                                        logic [6:0] f7, logic rtype);
      if (valid && aluop == 2'b10 && rtype && f7 == 7'b0000001) return 4'b0010;
      if (aluop == 2'b00) return 4'b0010;
      if (aluop == 2'b11) return 4'b0000;
      if (aluop == 2'b01) begin
         if (f3 == 3'd0) return 4'b1000;
         if (f3 == 3'd1) return 4'b1010;
         if (f3 == 3'd4) return 4'b1100;
         return 4'b1001;
      end
      case (f3)
         3'd0:    return (rtype && f7[5]) ? 4'b0110 : 4'b0010;
         3'd1:    return 4'b0100;
         3'd2:    return 4'b1100;
         3'd4:    return 4'b0011;
         3'd5:    return f7[5] ? 4'b0111 : 4'b0101;
         3'd6:    return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   // Reference M-extension result using 64-bit integer arithmetic.
   function automatic logic [31:0] refMd(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
      longint sa, sb, ub, p;
      longint unsigned up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'h0, b});
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == SMIN && b == 32'hFFFF_FFFF) return a;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == SMIN && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb;
            return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   // Stall cycles including the accept cycle.
   function automatic int expectedStall(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
      if (f3[2]) begin
         if (b == 0) return 1;
         if (!f3[0] && a == SMIN && b == 32'hFFFF_FFFF) return 1;
         return XLEN + 1;
      end
`ifdef MDU_FAST_MUL_EN
      return 1;
`else
      return XLEN + 1;
`endif
   endfunction

   // Called just after a rising edge; returns just after the edge that consumes the result.
   task automatic runMop(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input int holdCycles);
      int stalls;
      logic [31:0] expRes;
      expRes = refMd(f3, a, b);
      applyStimulus(1'b1, 2'b10, 7'b0000001, f3, 1'b1, a, b, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("f3=%0d sel_at_accept", f3), bus.md_sel, 0);
      stalls = 0;
      while (bus.stall_o && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      checkOutput($sformatf("f3=%0d a=%h b=%h stall_len", f3, a, b), stalls, expectedStall(f3, a, b));
      checkOutput($sformatf("f3=%0d md_sel", f3), bus.md_sel, 1);
      checkOutput($sformatf("f3=%0d a=%h b=%h md_result", f3, a, b), bus.md_result, expRes);
      checkOutput($sformatf("f3=%0d op_during_mop", f3), bus.Operation, 4'b0010);
      repeat (holdCycles) begin
         @(negedge clk);
         checkOutput("hold md_sel", bus.md_sel, 1);
         checkOutput("hold stall_o", bus.stall_o, 0);
         checkOutput("hold md_result", bus.md_result, expRes);
      end
      bus.ex_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.ex_ready_i = 1'b0;
      bus.valid_i    = 1'b0;
   endtask

   initial begin
      logic [1:0]  aluop;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        rtype, valid;
      logic [31:0] a, b;
      int          kind;
      logic [2:0]  brF3 [4] = '{3'd0, 3'd1, 3'd4, 3'd5};

      applyStimulus(1'b0, 2'b00, 7'h0, 3'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #12;
      checkOutput("reset md_sel", bus.md_sel, 0);
      checkOutput("reset md_result", bus.md_result, 0);
      checkOutput("reset stall_o", bus.stall_o, 0);
      checkOutput("reset Operation", bus.Operation, 4'b0010);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(1'b1, 2'b10, 7'b0100000, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      #1 checkOutput("addi imm10", bus.Operation, 4'b0010);
      bus.is_rtype_i = 1'b1;
      #1 checkOutput("sub rtype", bus.Operation, 4'b0110);
      bus.Funct3 = 3'b100;
      #1 checkOutput("xor f7_5", bus.Operation, 4'b0011);

      for (int i = 0; i < 30; i++) begin
         aluop = 2'($urandom_range(0, 3));
         if (aluop == 2'b01) f3 = brF3[$urandom_range(0, 3)];
         else begin
            f3 = 3'($urandom_range(0, 6));
            if (f3 == 3'd3) f3 = 3'd7;
         end
         kind  = $urandom_range(0, 2);
         f7    = (kind == 0) ? 7'b0100000 : (kind == 1) ? 7'b0000001 : 7'($urandom);
         rtype = 1'($urandom);
         valid = 1'($urandom);
         applyStimulus(valid, aluop, f7, f3, rtype, $urandom, $urandom, 1'b0, 1'b1);
         #1;
         checkOutput($sformatf("decode v=%0d op=%0d f3=%0d f7=%h r=%0d", valid, aluop, f3, f7, rtype),
                     bus.Operation, refOp(valid, aluop, f3, f7, rtype));
         checkOutput("decode stall under flush", bus.stall_o, 0);
      end
      applyStimulus(1'b0, 2'b00, 7'h0, 3'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      runMop(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
      runMop(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      runMop(3'd4, 32'hFFFF_FFF9, 32'd2, 5);
      runMop(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
      runMop(3'd5, 32'd100, 32'd0, 0);
      runMop(3'd4, SMIN, 32'hFFFF_FFFF, 0);
      runMop(3'd6, SMIN, 32'hFFFF_FFFF, 0);
      runMop(3'd0, 32'd6, 32'd7, 1);

      applyStimulus(1'b1, 2'b10, 7'b0000001, 3'd4, 1'b1, 32'd1000, 32'd7, 1'b0, 1'b0);
      repeat (11) @(negedge clk);
      bus.flush_i = 1'b1;
      #1;
      checkOutput("flush stall_o", bus.stall_o, 0);
      checkOutput("flush md_sel", bus.md_sel, 0);
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
      bus.valid_i = 1'b0;
      @(negedge clk);
      checkOutput("after flush stall_o", bus.stall_o, 0);
      checkOutput("after flush md_sel", bus.md_sel, 0);
      @(posedge clk);
      #1;

      runMop(3'd7, 32'd1000, 32'd7, 0);
      applyStimulus(1'b1, 2'b10, 7'b0000001, 3'd2, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async reset md_sel", bus.md_sel, 0);
      checkOutput("async reset md_result", bus.md_result, 0);
      checkOutput("async reset stall follows decode", bus.stall_o, 1);
      bus.valid_i = 1'b0;
      #1 checkOutput("async reset stall idle", bus.stall_o, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 16; i++) begin
         f3   = 3'($urandom_range(0, 7));
         kind = $urandom_range(0, 5);
         case (kind)
            0: begin a = $urandom; b = 32'h0; end
            1: begin a = SMIN; b = 32'hFFFF_FFFF; end
            2: begin
               a = $urandom % 256;
               b = $urandom % 256 + 1;
               if ($urandom % 2 == 1) a = -a;
               if ($urandom % 2 == 1) b = -b;
            end
            default: begin a = $urandom; b = $urandom; end
         endcase
         runMop(f3, a, b, $urandom_range(0, 2));
         if ($urandom % 2 == 1) begin
            @(posedge clk);
            #1;
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
